// File: rtl/instr_issue_sequencer_pkg.sv
// Shared types and constants for the instruction issue sequencer.
// Program storage geometry, issue timing, halt sentinel and FSM state encoding.
package instr_issue_sequencer_pkg;

    localparam int          DEPTH     = 16;
    localparam int          ADDR_W    = 4;
    localparam int          ISSUE_GAP = 5;
    localparam int          GAP_W     = 3;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [ADDR_W:0] DEPTH_LEN = 5'd16;
    localparam logic [GAP_W-1:0] GAP_INIT = 3'(ISSUE_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // Clamp a requested program length to the storage depth.
    function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] len);
        logic [ADDR_W:0] res;
        if (len > DEPTH_LEN) begin
            res = DEPTH_LEN;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/instr_issue_sequencer_instr_store.sv
// Program storage: DEPTH x 32 register array, one synchronous write port and one
// asynchronous read port. Deliberately not reset so a loaded program survives reset.
module instr_store
    import instr_issue_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_issue_sequencer.sv
// Feeds a multicycle CPU one stored instruction at a time: word presented in FETCH,
// one-cycle newinstr strobe after ISSUE, then a fixed gap before the next fetch.
module instr_issue_sequencer
    import instr_issue_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    output logic [31:0]       instrword,
    output logic              newinstr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    seq_state_e        state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [ADDR_W:0]   len_r, len_s;
    logic [GAP_W-1:0]  gap_r, gap_s;
    logic [31:0]       word_r, word_s;
    logic              newinstr_r, busy_r, done_r;
    logic              we_s;
    logic [31:0]       rdata_s;

    instr_store u_store (
        .clock (clock),
        .we    (we_s),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_r),
        .rdata (rdata_s)
    );

    // Next-state and datapath decode
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        len_s   = len_r;
        gap_s   = gap_r;
        word_s  = word_r;
        we_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                we_s = load_en;
                if (start) begin
                    if (prog_len != 5'd0) begin
                        len_s   = sat_len(prog_len);
                        pc_s    = 4'd0;
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                // The sentinel ends the run without disturbing the presented word
                if (rdata_s == HALT_WORD) begin
                    state_s = ST_DONE;
                end else begin
                    word_s  = rdata_s;
                    state_s = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                gap_s   = GAP_INIT;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (gap_r != 3'd0) begin
                    gap_s = gap_r - 3'd1;
                end else if ({1'b0, pc_r} == (len_r - 5'd1)) begin
                    state_s = ST_DONE;
                end else begin
                    pc_s    = pc_r + 4'd1;
                    state_s = ST_FETCH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pc_r       <= 4'd0;
            len_r      <= 5'd0;
            gap_r      <= 3'd0;
            word_r     <= 32'd0;
            newinstr_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            len_r      <= len_s;
            gap_r      <= gap_s;
            word_r     <= word_s;
            newinstr_r <= (state_r == ST_ISSUE);
            busy_r     <= (state_s == ST_FETCH) || (state_s == ST_ISSUE) || (state_s == ST_WAIT);
            done_r     <= (state_s == ST_DONE);
        end
    end

    assign instrword = word_r;
    assign newinstr  = newinstr_r;
    assign pc        = pc_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Self-checking bench: a list-based model of the program predicts the pulse train,
// pulse timing (period 7, first pulse 3 clocks after start) and completion cycle.
module tb_instr_issue_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic [4:0]  prog_len;
    logic        start;
    logic [31:0] instrword;
    logic        newinstr;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem_m [16];
    logic [31:0] last_w;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    instr_issue_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .prog_len  (prog_len),
        .start     (start),
        .instrword (instrword),
        .newinstr  (newinstr),
        .pc        (pc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic load_word(input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clock);
        load_en = 1'b0;
        mem_m[a] = d;
    endtask

    // Run one program and compare the whole pulse train against the model.
    task automatic run_prog(input logic [4:0] len_in, input bit poke,
                            input bit ld, input logic [3:0] ld_a, input logic [31:0] ld_d);
        logic [31:0] exp_w[$];
        int eff, exp_done_c, c, got, done_c;
        bit halted;
        logic [31:0] prev;
        if (ld) mem_m[ld_a] = ld_d;
        eff = (len_in > 5'd16) ? 16 : int'(len_in);
        halted = (eff == 0);
        for (int i = 0; i < eff; i++) begin
            if (mem_m[i] == HALT) begin
                halted = 1'b1;
                break;
            end
            exp_w.push_back(mem_m[i]);
        end
        exp_done_c = halted ? 1 + 7 * exp_w.size() : 7 * exp_w.size();
        @(negedge clock);
        start = 1'b1; prog_len = len_in;
        load_en = ld; load_addr = ld_a; load_data = ld_d;
        @(negedge clock);
        start = 1'b0; load_en = 1'b0;
        vectors++;
        if (busy !== (eff > 0)) begin
            miscompares++;
            $display("FAIL busy_after_start: got %b want %b", busy, (eff > 0));
        end
        c = 0; got = 0; done_c = -1; prev = instrword;
        while (done_c < 0 && c < 300) begin
            @(negedge clock);
            c++;
            if (poke && c == 10) begin
                start = 1'b1; prog_len = 5'd3;
                load_en = 1'b1; load_addr = 4'd0; load_data = ~mem_m[0];
            end else begin
                start = 1'b0; load_en = 1'b0;
            end
            if (newinstr) begin
                vectors++;
                if (got >= exp_w.size() || c != 2 + 7 * got || instrword !== exp_w[got] || prev !== instrword) begin
                    miscompares++;
                    $display("FAIL pulse%0d: cycle %0d word %h prev %h, want cycle %0d word %h",
                             got, c, instrword, prev, 2 + 7 * got,
                             (got < exp_w.size()) ? exp_w[got] : 32'h0);
                end
                got++;
            end
            prev = instrword;
            if (done) done_c = c;
        end
        if (exp_w.size() > 0) last_w = exp_w[exp_w.size() - 1];
        vectors++;
        if (done_c != exp_done_c) begin
            miscompares++;
            $display("FAIL done_cycle: got %0d want %0d", done_c, exp_done_c);
        end
        vectors++;
        if (got != exp_w.size()) begin
            miscompares++;
            $display("FAIL pulse_count: got %0d want %0d", got, exp_w.size());
        end
        vectors++;
        if (instrword !== last_w || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL end_state: word %h busy %b want word %h busy 0", instrword, busy, last_w);
        end
    endtask

    task automatic load_t2;
        load_word(4'd0, 32'h8C01_0000);
        load_word(4'd1, 32'h8C02_0001);
        load_word(4'd2, 32'h8C03_0002);
        load_word(4'd3, 32'h0022_2020);
        load_word(4'd4, 32'h0083_2822);
        load_word(4'd5, 32'hAC05_0003);
    endtask

    task automatic test_reset;
        vectors++;
        if (instrword !== 32'd0 || newinstr !== 1'b0 || pc !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_init: w %h n %b pc %h b %b d %b want all 0", instrword, newinstr, pc, busy, done);
        end
        @(negedge clock);
        start = 1'b1; prog_len = 5'd6;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        vectors++;
        if (newinstr !== 1'b1 || pc !== 4'd1) begin
            miscompares++;
            $display("FAIL pre_reset_pulse: n %b pc %h want 1 1", newinstr, pc);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (instrword !== 32'd0 || newinstr !== 1'b0 || pc !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: w %h n %b pc %h b %b d %b want all 0", instrword, newinstr, pc, busy, done);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        last_w = 32'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            vectors++;
            if (newinstr !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle: n %b b %b want 0 0", newinstr, busy);
            end
        end
    endtask

    task automatic test_basic;
        run_prog(5'd6, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_halt;
        load_word(4'd2, HALT);
        run_prog(5'd6, 1'b0, 1'b0, 4'd0, 32'd0);
        vectors++;
        if (instrword !== 32'h8C02_0001) begin
            miscompares++;
            $display("FAIL halt_word_kept: got %h want 8c020001", instrword);
        end
        load_word(4'd2, 32'h8C03_0002);
    endtask

    task automatic test_zero_len_and_busy_load;
        run_prog(5'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        run_prog(5'd6, 1'b1, 1'b0, 4'd0, 32'd0);
        run_prog(5'd6, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_load_with_start;
        run_prog(5'd3, 1'b0, 1'b1, 4'd0, 32'h1234_5678);
        run_prog(5'd20, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_random;
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < 3; k++) begin
                logic [31:0] d;
                d = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
                load_word(4'($urandom_range(0, 15)), d);
            end
            run_prog(5'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), $urandom);
        end
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = 4'd0; load_data = 32'd0;
        prog_len = 5'd0; start = 1'b0; last_w = 32'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            load_word(4'(i), 32'h0100_0000 + 32'(i));
        end
        load_t2();
        test_reset();
        test_basic();
        test_halt();
        test_zero_len_and_busy_load();
        test_load_with_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
